// File: rtl/tmr_tx_scheduler.sv
// tmr_tx_scheduler: sends one buffered frame R times back-to-back with inter-copy gaps,
// stamping each copy's redundancy ID (1..R) into the byte at offset WHEREISID.
module tmr_tx_scheduler #(
    parameter int WHEREISID = 0,
    parameter int R = 3,
    parameter int GAP = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    output logic [3:0]        copy_id,
    output logic              busy,
    output logic              done
);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [ADDR_W-1:0] ID_AT = ADDR_W'(WHEREISID);
    localparam logic [3:0] LAST = 4'(R);
    // GAP-1 wait clocks plus the FETCH clock give GAP idle clocks between copies
    localparam logic [GW-1:0] GAP_LD = GW'(GAP - 2);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP_WAIT, FIN} state_t;

    state_t state, nxt;
    logic [ADDR_W-1:0] len, idx;
    logic [GW-1:0] gap_cnt;
    logic last_byte, gap_end;

    always_comb begin
        last_byte = idx == len - 1'b1;
        gap_end = gap_cnt == '0;
        nxt = state;
        case (state)
            IDLE:     nxt = start && frame_len != '0 ? FETCH : IDLE;
            FETCH:    nxt = SEND;
            SEND:     nxt = !last_byte ? SEND : copy_id == LAST ? FIN : GAP_WAIT;
            GAP_WAIT: nxt = gap_end ? FETCH : GAP_WAIT;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            len <= '0;
            idx <= '0;
            gap_cnt <= '0;
            rd_addr <= '0;
            tx_en <= 1'b0;
            tx_data <= '0;
            copy_id <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= state == FIN;
            tx_en <= state == SEND;
            // rd_data during SEND always holds the byte at index idx
            tx_data <= state != SEND ? '0 : idx == ID_AT ? {4'b0, copy_id} : rd_data;
            case (state)
                IDLE:
                    if (nxt == FETCH) begin
                        len <= frame_len;
                        copy_id <= 4'd1;
                        rd_addr <= '0;
                        busy <= 1'b1;
                    end
                FETCH: begin
                    rd_addr <= ADDR_W'(1);
                    idx <= '0;
                end
                SEND: begin
                    rd_addr <= rd_addr + 1'b1;
                    idx <= idx + 1'b1;
                    if (last_byte) gap_cnt <= GAP_LD;
                end
                GAP_WAIT:
                    if (gap_end) begin
                        copy_id <= copy_id + 4'd1;
                        rd_addr <= '0;
                    end else gap_cnt <= gap_cnt - 1'b1;
                FIN: begin
                    busy <= 1'b0;
                    copy_id <= '0;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_tmr_tx_scheduler.sv
// tb_tmr_tx_scheduler: directed vectors with hand-computed expectations for the TMR transmit scheduler.
module tb_tmr_tx_scheduler;
    logic clk = 0, rst = 1, start = 0, start1 = 0;
    logic [11:0] frame_len = 0, frame_len1 = 0, rd_addr, rd_addr1;
    logic [7:0] rd_data, rd_data1, tx_data, tx_data1;
    logic [7:0] mem [0:4095];
    logic tx_en, tx_en1, busy, busy1, done, done1;
    logic [3:0] copy_id, copy_id1;
    int vectors = 0, miscompares = 0;
    logic [7:0] got[$], ref_q[$];
    logic [3:0] ids[$];
    int gaps[$];
    int lat, first;
    bit busy_ok;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        rd_data1 <= mem[rd_addr1];
    end

    tmr_tx_scheduler #(.WHEREISID(2), .R(3), .GAP(12), .ADDR_W(12)) u0 (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_en(tx_en), .tx_data(tx_data), .copy_id(copy_id),
        .busy(busy), .done(done)
    );

    tmr_tx_scheduler #(.WHEREISID(0), .R(3), .GAP(12), .ADDR_W(12)) u1 (
        .clk(clk), .rst(rst), .start(start1), .frame_len(frame_len1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .tx_en(tx_en1), .tx_data(tx_data1), .copy_id(copy_id1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Starts u0 with len; poke re-pulses start and changes frame_len during copy 2.
    task automatic run(input logic [11:0] len, input bit poke);
        int cyc, low;
        bit seen;
        got.delete(); ids.delete(); gaps.delete();
        busy_ok = 1; first = -1; cyc = 0; low = 0; seen = 0;
        @(negedge clk); frame_len = len; start = 1;
        @(negedge clk);
        while (cyc < 400) begin
            if (tx_en) begin
                if (seen && low > 0) gaps.push_back(low);
                if (!seen) first = cyc;
                got.push_back(tx_data); ids.push_back(copy_id);
                seen = 1; low = 0;
            end else if (seen) low++;
            if (done) break;
            if (!busy) busy_ok = 0;
            start = poke && got.size() == 7;
            frame_len = (poke && got.size() >= 7) ? 12'd9 : len;
            @(negedge clk); cyc++;
        end
        lat = done ? cyc : -1;
    endtask

    task automatic verify(input string tag, input int len, input int lat_exp);
        int exp;
        check({tag, "_nbytes"}, got.size(), 3 * len);
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_first_tx"}, first, 2);
        check({tag, "_busy_held"}, busy_ok, 1);
        check({tag, "_ngaps"}, gaps.size(), 2);
        foreach (gaps[k]) check({tag, "_gap"}, gaps[k], 12);
        if (got.size() == 3 * len)
            for (int c = 1; c <= 3; c++)
                for (int i = 0; i < len; i++) begin
                    exp = (i == 2) ? c : mem[i];
                    check({tag, "_byte"}, got[(c-1)*len+i], exp);
                    check({tag, "_id"}, ids[(c-1)*len+i], c);
                end
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_id_at_done"}, copy_id, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_tx"}, tx_en, 0);
    endtask

    initial begin
        int n, cyc, d, seen_any;
        logic [7:0] a, b, c, v;
        logic [7:0] bytes1[$];
        bit same;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i + 32);
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13; mem[4] = 8'h14;
        repeat (3) @(negedge clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_busy", busy, 0);
        check("rst_copy_id", copy_id, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_tx_data", tx_data, 0);
        rst = 0;
        @(negedge clk);

        run(12'd5, 0);
        ref_q = got;
        if (got.size() == 15)
            for (int i = 0; i < 5; i++) if (i != 2) begin
                a = got[i]; b = got[5+i]; c = got[10+i];
                v = (a == b || a == c) ? a : b;
                check("voter_byte", v, mem[i]);
            end
        verify("basic", 5, 41);

        @(negedge clk); frame_len = 0; start = 1;
        @(negedge clk); start = 0;
        seen_any = 0;
        repeat (30) begin
            if (busy || tx_en || done) seen_any = 1;
            @(negedge clk);
        end
        check("len0_ignored", seen_any, 0);

        run(12'd2, 0);
        verify("len2", 2, 32);

        run(12'd5, 1);
        same = got.size() == ref_q.size();
        if (same) foreach (got[k]) if (got[k] !== ref_q[k]) same = 0;
        check("poke_identical", same, 1);
        verify("poke", 5, 41);
        frame_len = 5;

        @(negedge clk); frame_len1 = 1; start1 = 1;
        @(negedge clk); start1 = 0;
        d = -1; cyc = 0;
        while (cyc < 60 && d < 0) begin
            if (tx_en1) bytes1.push_back(tx_data1);
            if (done1) d = cyc;
            @(negedge clk); cyc++;
        end
        check("len1_nbytes", bytes1.size(), 3);
        if (bytes1.size() == 3) for (int k = 0; k < 3; k++) check("len1_byte", bytes1[k], k + 1);
        check("len1_latency", d, 29);

        @(negedge clk); frame_len = 5; start = 1;
        @(negedge clk); start = 0;
        n = 0;
        for (int k = 0; k < 60 && n < 7; k++) begin
            @(negedge clk);
            if (tx_en) n++;
        end
        check("rst_mid_reached", n, 7);
        check("rst_mid_id_before", copy_id, 2);
        #2 rst = 1;
        #1;
        check("rst_mid_tx_en", tx_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_copy_id", copy_id, 0);
        seen_any = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || tx_en) seen_any = 1;
        end
        rst = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || tx_en) seen_any = 1;
        end
        check("rst_mid_quiet", seen_any, 0);

        run(12'd5, 0);
        verify("after_rst", 5, 41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
